// File: rtl/fetch_entry_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_entry_queue
//  Brief    : In-order circular buffer between the frontend realigner and
//             decode, with flush and optional empty-queue bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_entry_queue #(
    parameter int unsigned CVA6Cfg       = 0,
    parameter type         FETCH_ENTRY_T = logic [63:0],
    parameter int unsigned DEPTH         = 4,
    parameter bit          FALL_THROUGH  = 1'b0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              push_valid_i,
    input  logic [$bits(FETCH_ENTRY_T)-1:0]   push_entry_i,
    output logic                              push_ready_o,
    output logic [$bits(FETCH_ENTRY_T)-1:0]   fetch_entry_o,
    output logic                              fetch_entry_valid_o,
    input  logic                              fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]            usage_o
);

    localparam int unsigned c_entry_w = $bits(FETCH_ENTRY_T);
    localparam int unsigned c_ptr_w   = $clog2(DEPTH);
    localparam int unsigned c_cnt_w   = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_cnt_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);

    logic [c_entry_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic w_not_empty;
    logic w_push_fire;
    logic w_pop_fire;
    logic w_bypass;
    logic w_store;
    logic w_advance;

    assign w_not_empty  = (r_count != '0);
    assign push_ready_o = (r_count != c_cnt_depth);
    assign usage_o      = r_count;

    assign w_push_fire  = push_valid_i && push_ready_o && !flush_i;
    assign w_pop_fire   = fetch_entry_valid_o && fetch_entry_ready_i && !flush_i;

    // An entry handed straight through an empty queue never touches storage.
    assign w_bypass     = w_push_fire && w_pop_fire && !w_not_empty;
    assign w_store      = w_push_fire && !w_bypass;
    assign w_advance    = w_pop_fire && !w_bypass;

    generate
        if (FALL_THROUGH) begin : g_fall_through
            // Bypass is suppressed while reset is held so outputs read idle.
            assign fetch_entry_valid_o = w_not_empty || (push_valid_i && !rst_i);
            assign fetch_entry_o       = (w_not_empty || rst_i) ? r_mem[r_rd_ptr]
                                                                : push_entry_i;
        end else begin : g_registered
            assign fetch_entry_valid_o = w_not_empty;
            assign fetch_entry_o       = r_mem[r_rd_ptr];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_advance) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_store, w_advance})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            r_mem[r_wr_ptr] <= push_entry_i;
        end
    end

`ifndef SYNTHESIS
    logic [c_ptr_w-1:0] w_ptr_diff;
    assign w_ptr_diff = r_wr_ptr - r_rd_ptr;

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_push_fire && (r_count == c_cnt_depth)))
                else $error("fetch_entry_queue: push while full");
            assert (r_count <= c_cnt_depth)
                else $error("fetch_entry_queue: count overflow (cfg %0d)", CVA6Cfg);
            assert ((r_count == c_cnt_depth) || (r_count == {1'b0, w_ptr_diff}))
                else $error("fetch_entry_queue: count/pointer mismatch");
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/fetch_entry_queue.md
# fetch_entry_queue

Buffering producer for the fetch-to-decode handshake. It accepts fetch entries from the frontend realigner and presents them in order on `fetch_entry_o`/`fetch_entry_valid_o`. The decode stage drains it through `fetch_entry_ready_i`. Storage is a circular buffer of `DEPTH` entries with flush support and an optional empty-bypass path.

## Interface
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration; carried for type consistency.
- `DEPTH`, default 4: number of entries; a power of two, ≥ 2.
- `FALL_THROUGH`, default 0: when 1, an entry pushed into an empty queue is presented combinationally in the same cycle.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  **asynchronous, active-high reset**.
- `flush_i`  in  1  discard all stored entries and any push in the same cycle.
- `push_valid_i`  in  1  frontend offers an entry.
- `push_entry_i`  in  `$bits(ariane_pkg::fetch_entry_t)`  entry offered.
- `push_ready_o`  out  1  queue not full.
- `fetch_entry_o`  out  `$bits(ariane_pkg::fetch_entry_t)`  head entry.
- `fetch_entry_valid_o`  out  1  head entry valid.
- `fetch_entry_ready_i`  in  1  decode accepts the head entry.
- `usage_o`  out  `$clog2(DEPTH)+1`  number of stored entries, 0..DEPTH.

## Operation
- State: `rd_ptr` and `wr_ptr` (each `$clog2(DEPTH)` bits, wrap modulo DEPTH), `count` (`$clog2(DEPTH)+1` bits), storage array.
- Push fires when `push_valid_i && push_ready_o && !flush_i`. It writes `mem[wr_ptr]` and increments `wr_ptr`.
- Pop fires when `fetch_entry_valid_o && fetch_entry_ready_i && !flush_i`. It increments `rd_ptr`.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when both or neither fire.
- `push_ready_o = (count != DEPTH)`. It depends on registered state only; there is no pop-through when full.
- `fetch_entry_valid_o`:
  - `FALL_THROUGH=0`: `count != 0`.
  - `FALL_THROUGH=1`: `(count != 0) || push_valid_i`.
- `fetch_entry_o = mem[rd_ptr]` when `count != 0`. When `count == 0` and `FALL_THROUGH=1`, it is `push_entry_i`.
- Bypass consumed in the same cycle (`FALL_THROUGH=1`, count 0, push and pop both fire): the entry is not stored and `count` stays 0.
- Flush: next cycle `count=0` and `rd_ptr=wr_ptr=0`. Push and pop in the flush cycle have no effect. Outputs are not gated by `flush_i`; the consumer discards during flush.
- Reset: all pointers, `count` and storage are cleared to 0.
  - Outputs under reset: `fetch_entry_valid_o=0`, `push_ready_o=1`, `usage_o=0`, `fetch_entry_o=0`.
  - A reset asserted mid-operation drops all content immediately.
- Entries, including their `ex` and `branch_predict` fields, are stored and returned bit-exact and strictly in push order.
- Assertions, simulation only:
  - No push when full.
  - `count ≤ DEPTH`.
  - `count == (wr_ptr − rd_ptr) mod DEPTH` except when full.

## Timing
- Latency: push at cycle N is visible at the head at N+1 when `FALL_THROUGH=0`, or at N when `FALL_THROUGH=1` and the queue is empty.
- Throughput: one push and one pop per cycle sustained.
- Full boundary: with `count=DEPTH`, `push_ready_o=0`. A pop at cycle N raises `push_ready_o` at N+1.
- Empty boundary: with `count=1`, a pop at N and no push gives `fetch_entry_valid_o=0` at N+1 (`FALL_THROUGH=0`).
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- Handshake: once `fetch_entry_valid_o` is high, `fetch_entry_o` is held stable until a pop or flush.

## Test plan
- **Reset:** assert `rst_i` mid-stream with 3 entries stored -> same cycle `fetch_entry_valid_o=0`, `usage_o=0`, `push_ready_o=1`. After release, the first pushed entry appears first.
- **Fill/drain, DEPTH=4, ready=0:** push A,B,C,D -> `usage_o`=1,2,3,4; `push_ready_o=0` after the 4th; a 5th offer E is not accepted. Raise ready -> A,B,C,D pop on consecutive cycles, then valid drops.
- **Streaming with wrap:** push 10 entries with address 0x80000000+4k while ready=1 every cycle -> output order k=0..9, `usage_o` settles at 1, no bubble across pointer wrap.
- **Simultaneous push/pop when full:** count=4, push_valid=1, ready=1 -> pop occurs, push is refused (ready was 0), next cycle `usage_o=3`, `push_ready_o=1`.
- **Flush:** count=3 with push and pop also asserted in the flush cycle -> next cycle `usage_o=0`, valid=0. A subsequent push X makes X the head.
- **FALL_THROUGH=1:** empty queue, push Y with ready=1 -> `fetch_entry_o=Y` and valid=1 in the same cycle, `usage_o` stays 0. With ready=0 -> Y is stored and `usage_o=1` the next cycle.
